// File: rtl/imm_extend_pipe.sv
// Two-stage pipelined LEGv8 immediate generator with valid/ready handshake and flush.
// Define IMM_BYTE_OFFSET_EN to emit B/CB immediates as byte offsets (scaled by 4).
module imm_extend_pipe #(
  parameter int unsigned WORD      = 64,
  parameter int unsigned INSTR_LEN = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [INSTR_LEN-1:0] instruction,
  input  logic                 flush,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WORD-1:0]      imm,
  output logic [2:0]           imm_kind,
  output logic                 illegal
);

  typedef enum logic [2:0] {
    KindNone = 3'd0,
    KindD    = 3'd1,
    KindB    = 3'd2,
    KindCb   = 3'd3,
    KindI    = 3'd4,
    KindIw   = 3'd5
  } kind_e;

  logic            s1_valid_q, s1_valid_d;
  kind_e           s1_kind_q, s1_kind_d;
  logic [25:0]     s1_field_q, s1_field_d;
  logic            s2_valid_q, s2_valid_d;
  logic [WORD-1:0] imm_q, imm_d;
  logic [2:0]      kind_q, kind_d;
  logic            illegal_q, illegal_d;

  logic  s1_adv, s2_adv, s1_load, s2_load;
  kind_e kind_dec;
  logic [63:0] ext;
  logic        ext_illegal;
  logic [1:0]  hw;
  logic [6:0]  iw_top;

  always_comb begin
    s2_adv   = !s2_valid_q || out_ready;
    s1_adv   = !s1_valid_q || s2_adv;
    in_ready = s1_adv && !flush;
    s1_load  = in_valid && in_ready;
    s2_load  = s1_valid_q && s2_adv && !flush;
  end

  always_comb begin
    kind_dec = KindNone;
    casez (instruction[31:21])
      11'b11111000010, 11'b11111000000:                  kind_dec = KindD;
      11'b000101?????:                                   kind_dec = KindB;
      11'b10110100???, 11'b10110101???, 11'b01010100???: kind_dec = KindCb;
      11'b1001000100?, 11'b1101000100?, 11'b1001001000?,
      11'b1011001000?, 11'b1101001000?:                  kind_dec = KindI;
      11'b110100101??, 11'b111100101??:                  kind_dec = KindIw;
      default:                                           kind_dec = KindNone;
    endcase
  end

  // Extension is done at full 64 bits and then truncated, so narrow WORDs just drop MSBs.
  always_comb begin
    ext         = '0;
    ext_illegal = 1'b0;
    hw          = s1_field_q[22:21];
    iw_top      = {1'b0, hw, 4'b0000} + 7'd16;
    case (s1_kind_q)
      KindD:  ext = {{55{s1_field_q[20]}}, s1_field_q[20:12]};
`ifdef IMM_BYTE_OFFSET_EN
      KindB:  ext = {{36{s1_field_q[25]}}, s1_field_q[25:0], 2'b00};
      KindCb: ext = {{43{s1_field_q[23]}}, s1_field_q[23:5], 2'b00};
`else
      KindB:  ext = {{38{s1_field_q[25]}}, s1_field_q[25:0]};
      KindCb: ext = {{45{s1_field_q[23]}}, s1_field_q[23:5]};
`endif
      KindI:  ext = {52'b0, s1_field_q[21:10]};
      KindIw: begin
        if ({25'b0, iw_top} > WORD) begin
          ext_illegal = 1'b1;
        end else begin
          ext = {48'b0, s1_field_q[20:5]} << {hw, 4'b0000};
        end
      end
      default: ext_illegal = 1'b1;
    endcase
  end

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_kind_d  = s1_kind_q;
    s1_field_d = s1_field_q;
    s2_valid_d = s2_valid_q;
    imm_d      = imm_q;
    kind_d     = kind_q;
    illegal_d  = illegal_q;
    if (flush) begin
      s1_valid_d = 1'b0;
      s2_valid_d = 1'b0;
    end else begin
      if (s1_adv) s1_valid_d = in_valid;
      if (s2_adv) s2_valid_d = s1_valid_q;
      if (s1_load) begin
        s1_kind_d  = kind_dec;
        s1_field_d = instruction[25:0];
      end
      if (s2_load) begin
        imm_d     = ext[WORD-1:0];
        kind_d    = s1_kind_q;
        illegal_d = ext_illegal;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_q <= 1'b0;
      s1_kind_q  <= KindNone;
      s1_field_q <= '0;
      s2_valid_q <= 1'b0;
      imm_q      <= '0;
      kind_q     <= 3'd0;
      illegal_q  <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_kind_q  <= s1_kind_d;
      s1_field_q <= s1_field_d;
      s2_valid_q <= s2_valid_d;
      imm_q      <= imm_d;
      kind_q     <= kind_d;
      illegal_q  <= illegal_d;
    end
  end

  assign out_valid = s2_valid_q;
  assign imm       = imm_q;
  assign imm_kind  = kind_q;
  assign illegal   = illegal_q;

endmodule

// File: doc/imm_extend_pipe.md
Name: imm_extend_pipe

Overview:
- Two-stage pipelined immediate generator for the pipelined LEGv8 decode path.
- Accepts one 32-bit instruction per cycle over a valid/ready handshake and classifies its format.
- Extracts the immediate field and produces a WORD-wide sign-, zero- or shift-extended value plus a format tag.
- Sits between the IF/ID register and the operand-select mux. Covers more formats than the single-cycle extender and supports stall/flush.

Parameters:
- WORD, 64: output immediate width; legal values 32..64.
- INSTR_LEN, 32: instruction width; fixed at 32, exposed for consistency.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  instruction present on `instruction`.
- in_ready  out  1  stage 1 can accept this cycle.
- instruction  in  INSTR_LEN  raw instruction.
- flush  in  1  kill all in-flight entries (branch mispredict).
- out_valid  out  1  result present.
- out_ready  in  1  consumer accepts result.
- imm  out  WORD  extended immediate.
- imm_kind  out  3  format tag: 0 NONE, 1 D (LDUR/STUR), 2 B, 3 CB (CBZ/CBNZ/B.cond), 4 I (ADDI/SUBI/ANDI/ORRI/EORI), 5 IW (MOVZ/MOVK).
- illegal  out  1  opcode unrecognised, or IW shift out of range.

Behaviour:
- Stage 1 (S1):
  - Registers the opcode class (decoded from instruction[31:21], x-don't-care matching as in `definitions.vh`) and the raw field.
  - Fields: D = [20:12], B = [25:0], CB = [23:5], I = [21:10], IW = [20:5] with hw = [22:21].
- Stage 2 (S2): extension, registered into imm, imm_kind and illegal.
  - D: sign-extend 9 bits.
  - B: sign-extend 26 bits.
  - CB: sign-extend 19 bits.
  - I: zero-extend 12 bits.
  - IW: zero-extend 16 bits, then shift left by hw*16. If hw*16+16 > WORD: imm=0 and illegal=1.
  - NONE: imm=0, illegal=1.
- Handshake:
  - s2_adv = !s2_valid | out_ready.
  - s1_adv = !s1_valid | s2_adv.
  - in_ready = s1_adv. This is a combinational chain; no skid buffer.
  - Transfer occurs when valid & ready are both high on the same edge.
- Latency is exactly 2 cycles from input accept to out_valid with out_ready held high. Throughput is 1 per cycle.
- Output hold: while out_valid=1 and out_ready=0, imm, imm_kind and illegal hold stable, and S1 holds if occupied.
- Back-to-back: when both stages are full and out_ready=1, the S1 contents move to S2 and a new input is accepted on the same edge.
- flush:
  - Clears s1_valid and s2_valid on the next edge. This has priority over any advance.
  - An input presented in the flush cycle is discarded.
  - in_ready is forced to 0 during flush.
- reset: s1_valid=0, s2_valid=0, out_valid=0, imm=0, imm_kind=0, illegal=0. Reset overrides flush and handshake, and clears mid-operation entries without producing an output.
- Data registers update only on stage advance. The valid bits alone gate visibility.
- Width rule: sign extension replicates the field MSB up to bit WORD-1. When WORD=32, B and CB results are truncated to the low 32 bits without error.

Optional Feature:
- Macro: IMM_BYTE_OFFSET_EN.
- Defined: B and CB results are shifted left 2 before registering (word offset becomes byte offset), keeping sign. D, I and IW are unaffected.
- Undefined: all immediates are emitted unscaled, and the PC adder performs the shift.

Test Plan:
- LDUR, instruction 0xF85FF000 (imm9=0x1FF), out_ready=1 -> after 2 cycles: imm=0xFFFFFFFFFFFFFFFF, imm_kind=1, illegal=0.
- B, imm26=0x2000000 -> imm=0xFFFFFFFFFE000000, kind=2. With IMM_BYTE_OFFSET_EN: imm=0xFFFFFFFFF8000000.
- MOVZ, hw=3, imm16=0xBEEF -> imm=0xBEEF000000000000, kind=5. Same at WORD=32 -> imm=0, illegal=1.
- Backpressure: stream 4 ADDI (imm12=1,2,3,4), hold out_ready=0 for 3 cycles -> in_ready drops after 2 accepts, output held at 1. On release, outputs 1,2,3,4 in order with no loss or duplication.
- Flush with both stages full -> next cycle out_valid=0. A following CBZ with imm19=0x40000 -> imm=0xFFFFFFFFFFFC0000, kind=3.
- Reset asserted mid-stream for 1 cycle -> all outputs 0 and no stale result afterwards. Unknown opcode 0x00000000 -> kind=0, imm=0, illegal=1.
